// File: rtl/gpu_pkg.sv
// Shared types for the pixel writer: pixel record, writer FSM states and
// the framebuffer coordinate/channel widths.
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } writer_state_t;

  function automatic logic [3*CHANNEL_BITS-1:0] pack_rgb(pixel_t p);
    return {p.r, p.g, p.b};
  endfunction

endpackage

// File: rtl/gpu_pixel_writer_if.sv
// Pixel-stream and SRAM-write handshake bundle; the writer sits on the slave side.
interface gpu_pixel_writer_if
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 19
);

  logic                      pix_valid_i;
  logic [WIDTH_BITS-1:0]     x_i;
  logic [HEIGHT_BITS-1:0]    y_i;
  logic [CHANNEL_BITS-1:0]   r_i;
  logic [CHANNEL_BITS-1:0]   g_i;
  logic [CHANNEL_BITS-1:0]   b_i;
  logic                      pix_ready_o;
  logic [ADDR_BITS-1:0]      mem_addr_o;
  logic [3*CHANNEL_BITS-1:0] mem_data_o;
  logic                      mem_wr_o;
  logic                      mem_ack_i;

  modport slave (
    input  pix_valid_i, x_i, y_i, r_i, g_i, b_i, mem_ack_i,
    output pix_ready_o, mem_addr_o, mem_data_o, mem_wr_o
  );

  modport master (
    output pix_valid_i, x_i, y_i, r_i, g_i, b_i, mem_ack_i,
    input  pix_ready_o, mem_addr_o, mem_data_o, mem_wr_o
  );

endinterface

// File: rtl/gpu_pixel_fifo.sv
// Synchronous pixel FIFO with full/empty flags; pointers carry one extra wrap bit.
module gpu_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  pixel_t      mem [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; emptiness is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Buffers rasterizer pixels and issues framebuffer SRAM writes (IDLE/CALC/WRITE).
// Optional GPU_PIXEL_CLIP_EN drops off-screen pixels and counts them.
module gpu_pixel_writer
  import gpu_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int ADDR_BITS  = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  gpu_pixel_writer_if.slave  bus,
  output logic               busy_o,
  output logic [15:0]        drop_cnt_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SCREEN_W < 1 || SCREEN_H < 1) begin : g_param_check
    $error("gpu_pixel_writer: illegal parameter value");
  end

  // Constant-width multiply; the product wraps modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] pixel_addr(pixel_t p);
    return ADDR_BITS'(p.y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(p.x);
  endfunction

  pixel_t fifo_din, fifo_head;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic   accept;

  assign fifo_din = '{x: bus.x_i, y: bus.y_i, r: bus.r_i, g: bus.g_i, b: bus.b_i};
  assign bus.pix_ready_o = !fifo_full;
  assign accept = bus.pix_valid_i && !fifo_full;

`ifdef GPU_PIXEL_CLIP_EN
  logic        in_range;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign in_range  = (32'(bus.x_i) < 32'(SCREEN_W)) && (32'(bus.y_i) < 32'(SCREEN_H));
  assign fifo_push = accept && in_range;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !in_range && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign fifo_push  = accept;
  assign drop_cnt_o = '0;
`endif

  gpu_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  writer_state_t             state_q, state_d;
  pixel_t                    cur_q, cur_d;
  logic [ADDR_BITS-1:0]      addr_q, addr_d;
  logic [3*CHANNEL_BITS-1:0] data_q, data_d;
  logic                      wr_q, wr_d;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          state_d  = CALC;
        end
      end
      CALC: begin
        addr_d  = pixel_addr(cur_q);
        data_d  = pack_rgb(cur_q);
        wr_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        // Address and data stay frozen until the arbiter acknowledges.
        if (bus.mem_ack_i) begin
          wr_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_head;
            state_d  = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.mem_wr_o   = wr_q;
  assign busy_o         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Scoreboard bench for gpu_pixel_writer: stimulus pushes expected writes, a monitor checks them.
module tb_gpu_pixel_writer;
  import gpu_pkg::*;

  localparam int AB = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] drop_cnt;

  gpu_pixel_writer_if #(.ADDR_BITS(AB)) bus ();

  gpu_pixel_writer #(
    .SCREEN_W(640), .SCREEN_H(480), .ADDR_BITS(AB), .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_o     (busy),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0, failures = 0;
  int  writes = 0, last_len = 0, accepted = 0, exp_drop = 0, ack_mode = 0;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic wr_t model(int x, int y, int r, int g, int b);
    wr_t m;
    m.addr = AB'((y * 640 + x) % (1 << AB));
    m.data = {8'(r), 8'(g), 8'(b)};
    return m;
  endfunction

  function automatic bit clipped(int x, int y);
`ifdef GPU_PIXEL_CLIP_EN
    return (x >= 640) || (y >= 480);
`else
    return 1'b0;
`endif
  endfunction

  // Arbiter model: ack policy selected by ack_mode
  int wr_cyc = 0;
  initial begin
    bus.mem_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_wr_o) wr_cyc++;
      else              wr_cyc = 0;
      case (ack_mode)
        0:       bus.mem_ack_i = 1'b1;
        1:       bus.mem_ack_i = 1'b0;
        2:       bus.mem_ack_i = (wr_cyc == 4);
        default: bus.mem_ack_i = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // Monitor: a write completes on an edge where mem_wr_o and mem_ack_i are both high
  int  wr_len = 0;
  wr_t held;
  bit  stable;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !bus.mem_wr_o) begin
        wr_len = 0;
      end else begin
        if (wr_len == 0) begin
          held   = {bus.mem_addr_o, bus.mem_data_o};
          stable = 1'b1;
        end else if ({bus.mem_addr_o, bus.mem_data_o} != held) begin
          stable = 1'b0;
        end
        wr_len++;
        if (bus.mem_ack_i) begin
          wr_t e;
          writes++;
          last_len = wr_len;
          check("write_hold_stable", stable, 1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0d, expected no write", bus.mem_addr_o);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", bus.mem_addr_o, e.addr);
            check("write_data", bus.mem_data_o, e.data);
          end
          wr_len = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge, or leaves valid high on timeout
  task automatic send_pixel(int x, int y, int r, int g, int b, int budget, output bit ok);
    bus.pix_valid_i = 1'b1;
    bus.x_i = WIDTH_BITS'(x);
    bus.y_i = HEIGHT_BITS'(y);
    bus.r_i = 8'(r);
    bus.g_i = 8'(g);
    bus.b_i = 8'(b);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.pix_ready_o) begin
        if (clipped(x, y)) begin
          if (exp_drop < 65535) exp_drop++;
        end else begin
          exp_q.push_back(model(x, y, r, g, b));
        end
        accepted++;
        @(posedge clk);
        #1;
        bus.pix_valid_i = 1'b0;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int x, int y, int r, int g, int b);
    bit ok;
    send_pixel(x, y, r, g, b, 200, ok);
    if (!ok) check("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check("drain_complete", (busy || exp_q.size() != 0) ? 1 : 0, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ok;
    int base, wb;
    bus.pix_valid_i = 1'b0;
    bus.x_i = '0;
    bus.y_i = '0;
    bus.r_i = '0;
    bus.g_i = '0;
    bus.b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", bus.pix_ready_o, 1);
    check("reset_wr", bus.mem_wr_o, 0);
    check("reset_addr", bus.mem_addr_o, 0);
    check("reset_data", bus.mem_data_o, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", drop_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pixel, ack tied high: wr rises two edges after accept
    ack_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_pixel(200, 150, 50, 40, 80, 50, ok);
    check("single_accept", ok, 1);
    @(negedge clk);
    check("lat_wr_after_accept", bus.mem_wr_o, 0);
    @(negedge clk);
    check("lat_wr_in_calc", bus.mem_wr_o, 0);
    @(negedge clk);
    check("lat_wr_high", bus.mem_wr_o, 1);
    check("single_addr", bus.mem_addr_o, 96200);
    check("single_data", bus.mem_data_o, 24'h322850);
    @(negedge clk);
    check("single_busy_low", busy, 0);
    @(posedge clk);
    #1;

    // Ack delayed by three cycles
    ack_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send($urandom_range(0, 639), $urandom_range(0, 479), $urandom, $urandom, $urandom);
    wait_idle(100);
    check("delayed_write_len", last_len, 4);

    // Backpressure with ack held low
    ack_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    base = accepted;
    for (int i = 0; i < 9; i++)
      send($urandom_range(0, 639), $urandom_range(0, 479), $urandom, $urandom, $urandom);
    send_pixel(123, 45, 1, 2, 3, 20, ok);
    check("bp_tenth_blocked", ok, 0);
    check("bp_accepted", accepted - base, 9);
    check("bp_ready_low", bus.pix_ready_o, 0);
    check("bp_wr_pending", bus.mem_wr_o, 1);
    ack_mode = 0;
    send_pixel(123, 45, 1, 2, 3, 200, ok);
    check("bp_tenth_after_release", ok, 1);
    wait_idle(300);

    // Reset while a write is in flight with three pixels queued
    ack_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      send($urandom_range(0, 639), $urandom_range(0, 479), $urandom, $urandom, $urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_wr_o) break;
    end
    check("rst_reached_write", bus.mem_wr_o, 1);
    rst = 1'b1;
    #1;
    check("rst_wr_drops", bus.mem_wr_o, 0);
    check("rst_busy_drops", busy, 0);
    check("rst_ready", bus.pix_ready_o, 1);
    exp_q.delete();
    exp_drop = 0;
    wb = writes;
    ack_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_further_writes", writes, wb);
    check("rst_busy_after", busy, 0);

    // Clip boundaries (pushed and wrapped when clipping is compiled out)
    ack_mode = 0;
    wb = writes;
    send(640, 0, 9, 9, 9);
    send(0, 480, 8, 8, 8);
    send(639, 479, 7, 7, 7);
    wait_idle(100);
    check("clip_drop_cnt", drop_cnt, exp_drop);
    check("clip_write_count", writes - wb, 3 - exp_drop);

    // Randomized traffic with random ack timing
    ack_mode = 3;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 700), $urandom_range(0, 511), $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle(3000);
    check("random_drop_cnt", drop_cnt, exp_drop);

    // Full rectangle (0,0)-(200,150)
    ack_mode = 0;
    wb = writes;
    for (int y = 0; y <= 150; y++)
      for (int x = 0; x <= 200; x++)
        send(x, y, x, y, x + y);
    wait_idle(1000);
    check("rect_write_count", writes - wb, 201 * 151);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Downstream stage of `gpu_fill_rect` that turns its per-pixel stream (x, y, r, g, b) into framebuffer SRAM write transactions. It buffers pixels in a small FIFO, computes the linear address `y*SCREEN_W + x`, and runs a request/acknowledge write handshake to the memory arbiter. It back-pressures the rasterizer through `pix_ready_o`.

## Interface
- `SCREEN_W`, 640, framebuffer width in pixels
- `SCREEN_H`, 480, framebuffer height in pixels
- `ADDR_BITS`, 19, SRAM word-address width
- `FIFO_DEPTH`, 8, pixel FIFO entries; power of two, at least 2
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pix_valid_i`  in  1  pixel on the inputs is valid
- `x_i`  in  `WIDTH_BITS`  pixel column
- `y_i`  in  `HEIGHT_BITS`  pixel row
- `r_i`, `g_i`, `b_i`  in  `CHANNEL_BITS` each  pixel color
- `pix_ready_o`  out  1  writer can accept a pixel this cycle
- `mem_addr_o`  out  `ADDR_BITS`  SRAM word address
- `mem_data_o`  out  3*`CHANNEL_BITS`  packed {r,g,b}, r in the MSBs
- `mem_wr_o`  out  1  write request
- `mem_ack_i`  in  1  write accepted
- `busy_o`  out  1  FIFO non-empty or write in flight
- `drop_cnt_o`  out  16  clipped-pixel count

## Operation
- A pixel is accepted on a rising edge where `pix_valid_i && pix_ready_o` is true.
- `pix_ready_o = !fifo_full`. It ignores a same-cycle pop. A push and a pop in the same cycle when the FIFO is not full are both performed.
- The FSM has three states: IDLE, CALC, WRITE.
  - IDLE: if the FIFO is non-empty, pop the head, go to CALC. Otherwise stay.
  - CALC: register `mem_addr_o = y*SCREEN_W + x`, truncated to `ADDR_BITS`. Register `mem_data_o`. Go to WRITE.
  - WRITE: `mem_wr_o = 1`. Address and data are held stable. When `mem_ack_i` is sampled high, pop the next pixel and go to CALC if the FIFO is non-empty, else go to IDLE.
- `mem_ack_i` is ignored outside WRITE.
- The multiply uses a constant `SCREEN_W`, so it may be shift-add. The full product width is `ADDR_BITS`; overflow wraps modulo 2^`ADDR_BITS`.
- `busy_o = !fifo_empty || state != IDLE`. The command sequencer treats "rasterizer `done_o` plus `busy_o` low" as frame-complete.
- Reset at any time:
  - FIFO is emptied and the FSM goes to IDLE.
  - `mem_wr_o` drops at once, abandoning any in-flight write.
  - `drop_cnt_o` is cleared.

## Timing
- Reset values:
  - `pix_ready_o = 1`
  - `mem_wr_o = 0`
  - `mem_addr_o = 0`
  - `mem_data_o = 0`
  - `busy_o = 0`
  - `drop_cnt_o = 0`
- Latency: pixel accepted at edge N into an empty, idle writer → popped at N+1 → `mem_wr_o` high from edge N+2.
- An ack sampled in the first WRITE cycle gives a throughput of 1 pixel per 2 cycles.
- An ack delayed by k cycles stretches WRITE by k cycles.
- Full FIFO plus held ack: `pix_ready_o` stays low. Upstream holds its pixel; no data is lost.
- `busy_o` falls on the edge at which the last ack is sampled, if no pixels remain.

## Configuration
- `GPU_PIXEL_CLIP_EN` defined:
  - A valid pixel with `x_i >= SCREEN_W` or `y_i >= SCREEN_H` is consumed (handshake completes) but not pushed.
  - Each such pixel increments `drop_cnt_o`, which saturates at 0xFFFF.
- `GPU_PIXEL_CLIP_EN` undefined:
  - All pixels are pushed; out-of-range addresses wrap.
  - `drop_cnt_o` is tied to 0; the port is retained.

## Structure
- `gpu_pkg` holds:
  - `pixel_t` packed struct {x, y, r, g, b}, sized from `WIDTH_BITS` / `HEIGHT_BITS` / `CHANNEL_BITS` in `gpu_definitions.vh`
  - `writer_state_t` enum {IDLE, CALC, WRITE}
- One sub-module, `gpu_pixel_fifo`: synchronous FIFO of `pixel_t`, parameterized by depth, with full/empty flags and async active-high reset.
- The FSM and the address arithmetic stay in `gpu_pixel_writer`.

## Test plan
- Single pixel, ack returned same cycle:
  - Stimulus: (x=200, y=150, r=50, g=40, b=80), `CHANNEL_BITS`=8, ack tied high.
  - Response: `mem_wr_o` high 2 cycles after accept, `mem_addr_o`=96200, `mem_data_o`=0x322850, `busy_o` low the cycle after.
- Backpressure:
  - Stimulus: `mem_ack_i` held low, 10 pixels offered back-to-back.
  - Response: exactly 9 accepted (8 in FIFO + 1 in WRITE), `pix_ready_o` low. Releasing ack drains all 9 in order with correct addresses.
- Delayed ack:
  - Stimulus: ack returned 3 cycles after `mem_wr_o` rises.
  - Response: `mem_addr_o` and `mem_data_o` are unchanged across all 4 WRITE cycles.
- Clip:
  - Stimulus: with `GPU_PIXEL_CLIP_EN`, send (640, 0) and (0, 480), then (639, 479).
  - Response: `drop_cnt_o`=2, and one write at address 307199.
- Reset mid-write:
  - Stimulus: assert `rst` while in WRITE with 3 pixels queued.
  - Response: `mem_wr_o` drops immediately; after reset `busy_o`=0 and no further writes occur.
- Full rectangle:
  - Stimulus: `gpu_fill_rect` driving (0,0)-(200,150).
  - Response: 201×151 = 30351 writes, each address equal to y*640+x.
